// File: rtl/fxp_mult_if.sv
// Operand/result handshake bundle for the sequential fixed-point multiplier.
// The master side supplies operands and consumes results; the slave side is the multiplier.
interface fxp_mult_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic             overflow;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, overflow
    );
endinterface

// File: rtl/fxp_mult_seq.sv
// Signed fixed-point multiplier: shift-add on operand magnitudes over WIDTH cycles,
// then one finalise cycle for sign, rounding and range handling.
module fxp_mult_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 13,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic      clk,
    input  logic      rst,
    fxp_mult_if.slave bus
);
    localparam int AW  = 2 * WIDTH;
    localparam int PW  = 2 * WIDTH + 2;
    localparam int CW  = $clog2(WIDTH);
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic signed [PW-1:0] RND_BIAS = (ROUND != 0 && FRAC > 0) ? (PW'(1) << RSH) : '0;
    localparam logic signed [PW-1:0] MAX_V    = (PW'(1) << (WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MIN_V    = -(PW'(1) << (WIDTH - 1));

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic               sign_q;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   out_p_q, out_p_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q;

    logic               in_ready;
    logic               accept;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic signed [PW-1:0] prod, shifted;

    assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // |-2^(W-1)| wraps to 2^(W-1), which is exactly right as an unsigned magnitude.
    assign mag_a_in = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    assign mag_b_in = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d = acc_q;
        if (mag_b_q[cnt_q]) acc_d = acc_q + ({{WIDTH{1'b0}}, mag_a_q} << cnt_q);

        prod    = sign_q ? -signed'({2'b00, acc_q}) : signed'({2'b00, acc_q});
        shifted = (prod + RND_BIAS) >>> FRAC;
        ovf_d   = (shifted > MAX_V) || (shifted < MIN_V);
        out_p_d = shifted[WIDTH-1:0];
        if (ovf_d && SAT != 0)
            out_p_d = shifted[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_p_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                mag_a_q <= mag_a_in;
                mag_b_q <= mag_b_in;
                sign_q  <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
                acc_q   <= '0;
                cnt_q   <= '0;
            end
            unique case (state_q)
                IDLE: if (accept) state_q <= CALC;
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIN;
                end
                FIN: begin
                    out_p_q     <= out_p_d;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    // Retiring and accepting can share one edge; the next result starts at once.
                    out_valid_q <= 1'b0;
                    state_q     <= accept ? CALC : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.overflow  = ovf_q;
endmodule
